alarm_sequencer: RTL and testbench

//  Sequences the vehicle anti-theft alarm datapath: arm-delay, entry-delay and siren-duration timing from door and ignicao.

---
 rtl/alarm_sequencer.sv | 112 +++++++++++
 tb/tb_alarm_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - vehicle anti-theft alarm sequencer: arm, entry and siren timing
// One FSM plus one shared down-counter; every output is registered from next state/count.
module alarm_sequencer #(
  parameter int CNT_W   = 4,
  parameter int T_ARM   = 4,
  parameter int T_ENTRY = 6,
  parameter int T_ALARM = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             door,
  input  logic             ignicao,
  output logic             alarme,
  output logic [CNT_W-1:0] count,
  output logic             armed,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARM_WAIT = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ARM_LD   = CNT_W'(T_ARM);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(T_ENTRY);
  localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(T_ALARM);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = '0;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    nxt     = S_DISARMED;
    cnt_nxt = ZERO;
    // Ignition wins over every other input in every state.
    if (!ignicao) begin
      case (cur)
        S_DISARMED: begin
          if (!door) begin
            nxt     = S_ARM_WAIT;
            cnt_nxt = ARM_LD;
          end
        end
        S_ARM_WAIT: begin
          if (door) begin
            nxt     = S_ARM_WAIT;
            cnt_nxt = ARM_LD;
          end else if (count == ONE) begin
            nxt     = S_ARMED;
          end else begin
            nxt     = S_ARM_WAIT;
            cnt_nxt = count - ONE;
          end
        end
        S_ARMED: begin
          if (door) begin
            nxt     = S_ENTRY;
            cnt_nxt = ENTRY_LD;
          end else begin
            nxt     = S_ARMED;
          end
        end
        S_ENTRY: begin
          if (count == ONE) begin
            nxt     = S_ALARM;
            cnt_nxt = ALARM_LD;
          end else begin
            nxt     = S_ENTRY;
            cnt_nxt = count - ONE;
          end
        end
        S_ALARM: begin
          // An open door at the end of a burst starts another burst.
          if (count == ONE && door) begin
            nxt     = S_ALARM;
            cnt_nxt = ALARM_LD;
          end else if (count == ONE) begin
            nxt     = S_ARMED;
          end else begin
            nxt     = S_ALARM;
            cnt_nxt = count - ONE;
          end
        end
        default: begin
          nxt     = S_DISARMED;
          cnt_nxt = ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur    <= S_DISARMED;
      count  <= ZERO;
      alarme <= 1'b0;
      armed  <= 1'b0;
    end else begin
      cur    <= nxt;
      count  <= cnt_nxt;
      alarme <= (nxt == S_ALARM);
      armed  <= (nxt == S_ARMED) || (nxt == S_ENTRY) || (nxt == S_ALARM);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed scoreboard bench for alarm_sequencer
module tb_alarm_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       door = 1'b1;
  logic       ignicao = 1'b1;
  logic       alarme;
  logic [3:0] count;
  logic       armed;
  logic [2:0] state;

  typedef struct {
    logic [2:0] st;
    logic [3:0] cnt;
    logic       alm;
    logic       arm;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  alarm_sequencer #(.CNT_W(4), .T_ARM(4), .T_ENTRY(6), .T_ALARM(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .door   (door),
    .ignicao(ignicao),
    .alarme (alarme),
    .count  (count),
    .armed  (armed),
    .state  (state)
  );

  always #5 clock = ~clock;

  task automatic step(input logic r, input logic d, input logic ig,
                      input logic [2:0] es, input logic [3:0] ec, input string tag);
    exp_t e;
    logic [7:0] obs, want;
    reset   = r;
    door    = d;
    ignicao = ig;
    e.st  = es;
    e.cnt = ec;
    e.alm = (es == 3'd4);
    e.arm = (es == 3'd2) || (es == 3'd3) || (es == 3'd4);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e    = exp_q.pop_front();
    obs  = {state, count, alarme};
    want = {e.st, e.cnt, e.alm};
    total++;
    assert ({obs, armed} === {want, e.arm}) else begin
      bad++;
      $error("FAIL %s observed st=%0d cnt=%0d alarme=%b armed=%b expected st=%0d cnt=%0d alarme=%b armed=%b",
             e.tag, state, count, alarme, armed, e.st, e.cnt, e.alm, e.arm);
    end
  endtask

  // From DISARMED with door closed: four ARM_WAIT edges then ARMED.
  task automatic arm_up(input string tag);
    for (int c = 4; c >= 1; c--) step(1, 0, 0, 3'd1, 4'(c), tag);
    step(1, 0, 0, 3'd2, 4'd0, tag);
  endtask

  initial begin
    #2;
    // 1. reset dominates door and ignition
    step(0, 1, 1, 3'd0, 4'd0, "reset");
    // 2. arming countdown
    arm_up("arm");
    // 3. door bounce restarts ARM_WAIT
    step(1, 0, 1, 3'd0, 4'd0, "ign_disarm");
    step(1, 0, 0, 3'd1, 4'd4, "rearm");
    step(1, 0, 0, 3'd1, 4'd3, "rearm");
    step(1, 0, 0, 3'd1, 4'd2, "rearm");
    step(1, 1, 0, 3'd1, 4'd4, "door_restart");
    for (int c = 3; c >= 1; c--) step(1, 0, 0, 3'd1, 4'(c), "restart_cnt");
    step(1, 0, 0, 3'd2, 4'd0, "restart_armed");
    step(1, 0, 0, 3'd2, 4'd0, "armed_hold");
    // 4. entry then one siren burst back to ARMED
    step(1, 1, 0, 3'd3, 4'd6, "entry");
    for (int c = 5; c >= 1; c--) step(1, 0, 0, 3'd3, 4'(c), "entry_cnt");
    for (int c = 8; c >= 1; c--) step(1, 0, 0, 3'd4, 4'(c), "alarm_cnt");
    step(1, 0, 0, 3'd2, 4'd0, "alarm_end");
    // 5a. ignition cancels ENTRY
    step(1, 1, 0, 3'd3, 4'd6, "entry2");
    for (int c = 5; c >= 3; c--) step(1, 0, 0, 3'd3, 4'(c), "entry2_cnt");
    step(1, 0, 1, 3'd0, 4'd0, "entry_ign");
    // 5b. ignition beats door in ARMED
    arm_up("arm2");
    step(1, 1, 1, 3'd0, 4'd0, "armed_door_ign");
    // 6a. door held open re-triggers the burst
    arm_up("arm3");
    step(1, 1, 0, 3'd3, 4'd6, "entry3");
    for (int c = 5; c >= 1; c--) step(1, 1, 0, 3'd3, 4'(c), "entry3_cnt");
    for (int c = 8; c >= 1; c--) step(1, 1, 0, 3'd4, 4'(c), "burst1");
    step(1, 1, 0, 3'd4, 4'd8, "retrigger");
    for (int c = 7; c >= 1; c--) step(1, 0, 0, 3'd4, 4'(c), "burst2");
    step(1, 0, 0, 3'd2, 4'd0, "burst2_end");
    // 6b. reset mid-ALARM leaves no residual siren
    step(1, 1, 0, 3'd3, 4'd6, "entry4");
    for (int c = 5; c >= 1; c--) step(1, 0, 0, 3'd3, 4'(c), "entry4_cnt");
    step(1, 0, 0, 3'd4, 4'd8, "alarm4");
    step(1, 0, 0, 3'd4, 4'd7, "alarm4");
    step(0, 0, 0, 3'd0, 4'd0, "reset_alarm");
    step(1, 1, 0, 3'd0, 4'd0, "disarmed_door");
    step(1, 0, 0, 3'd1, 4'd4, "post_reset_arm");

    total++;
    assert (exp_q.size() === 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
